// File: rtl/hdc_vote_filter_pkg.sv
// rtl/hdc_vote_filter_pkg.sv - shared widths, state encoding and sizing helper for the vote filter
package hdc_vote_filter_pkg;

    localparam int LABEL_WIDTH    = 4;
    localparam int DISTANCE_WIDTH = 10;
    localparam int VOTE_WINDOW    = 8;

    // Counter width that can hold 0..window inclusive
    function automatic int vote_count_width(input int window);
        return $clog2(window + 1);
    endfunction

    localparam int VOTE_COUNT_WIDTH = vote_count_width(VOTE_WINDOW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VOTE = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/hdc_vote_filter_vote_window.sv
// rtl/hdc_vote_filter_vote_window.sv - per-modality confidence gate, label history, counters and majority vote
module vote_window
    import hdc_vote_filter_pkg::*;
#(
    parameter int WINDOW = VOTE_WINDOW
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 accept,
    input  logic                                 label_bit,
    input  logic [DISTANCE_WIDTH-1:0]            distance,
    input  logic [DISTANCE_WIDTH-1:0]            thresh,
    input  logic                                 prev_label,
    output logic                                 vote,
    output logic                                 rejected,
    output logic [vote_count_width(WINDOW)-1:0]  fill
);

    localparam int CW = vote_count_width(WINDOW);

    logic [WINDOW-1:0] hist;
    logic [CW-1:0]     count;
    logic [CW-1:0]     fill_q;
    logic              keep;
    logic              full;
    logic              evicted;
    logic [CW-1:0]     count_next;
    logic [CW:0]       count_x2;
    logic [CW:0]       fill_x1;

    // Gate decision, eviction and next ones-count; the oldest bit only leaves once the window is full
    always_comb begin
        keep       = (distance <= thresh);
        full       = (fill_q == CW'(WINDOW));
        evicted    = full & hist[WINDOW-1];
        count_next = count + CW'(label_bit) - CW'(evicted);
        count_x2   = {count, 1'b0};
        fill_x1    = {1'b0, fill_q};
        if (count_x2 > fill_x1) begin
            vote = 1'b1;
        end else if (count_x2 < fill_x1) begin
            vote = 1'b0;
        end else begin
            vote = prev_label;
        end
    end

    // History, counters and reject flag update only on an accepted result
    always_ff @(posedge clk) begin
        if (reset) begin
            hist     <= '0;
            count    <= '0;
            fill_q   <= '0;
            rejected <= 1'b0;
        end else if (accept) begin
            rejected <= ~keep;
            if (keep) begin
                hist  <= {hist[WINDOW-2:0], label_bit};
                count <= count_next;
                if (!full) begin
                    fill_q <= fill_q + CW'(1);
                end
            end
        end
    end

    assign fill = fill_q;

endmodule

// File: rtl/hdc_vote_filter.sv
// rtl/hdc_vote_filter.sv - two-modality sliding-window majority filter with IDLE/VOTE/OUT handshake
module hdc_vote_filter
    import hdc_vote_filter_pkg::*;
#(
    parameter int WINDOW = VOTE_WINDOW
) (
    input  logic                                 Clk_CI,
    input  logic                                 Reset_RI,
    input  logic                                 ValidIn_SI,
    output logic                                 ReadyOut_SO,
    input  logic [LABEL_WIDTH-1:0]               LabelIn_A_DI,
    input  logic [LABEL_WIDTH-1:0]               LabelIn_V_DI,
    input  logic [DISTANCE_WIDTH-1:0]            DistanceIn_A_DI,
    input  logic [DISTANCE_WIDTH-1:0]            DistanceIn_V_DI,
    input  logic [DISTANCE_WIDTH-1:0]            DistThresh_DI,
    output logic                                 ValidOut_SO,
    input  logic                                 ReadyIn_SI,
    output logic [LABEL_WIDTH-1:0]               LabelOut_A_DO,
    output logic [LABEL_WIDTH-1:0]               LabelOut_V_DO,
    output logic                                 Rejected_A_DO,
    output logic                                 Rejected_V_DO,
    output logic [vote_count_width(WINDOW)-1:0]  Fill_A_DO,
    output logic [vote_count_width(WINDOW)-1:0]  Fill_V_DO
);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   vote_a;
    logic   vote_v;
    logic   label_a_q;
    logic   label_v_q;
    logic   unused_label_bits;

    // Only bit 0 of each label carries the class
    assign unused_label_bits = ^{LabelIn_A_DI[LABEL_WIDTH-1:1], LabelIn_V_DI[LABEL_WIDTH-1:1]};

    // State register
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; VOTE is a fixed one-cycle pass
    always_comb begin
        state_next  = state;
        ReadyOut_SO = 1'b0;
        ValidOut_SO = 1'b0;
        accept      = 1'b0;
        case (state)
            ST_IDLE: begin
                ReadyOut_SO = 1'b1;
                accept      = ValidIn_SI;
                if (ValidIn_SI) begin
                    state_next = ST_VOTE;
                end
            end
            ST_VOTE: begin
                state_next = ST_OUT;
            end
            ST_OUT: begin
                ValidOut_SO = 1'b1;
                if (ReadyIn_SI) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    vote_window #(.WINDOW(WINDOW)) u_win_a (
        .clk        (Clk_CI),
        .reset      (Reset_RI),
        .accept     (accept),
        .label_bit  (LabelIn_A_DI[0]),
        .distance   (DistanceIn_A_DI),
        .thresh     (DistThresh_DI),
        .prev_label (label_a_q),
        .vote       (vote_a),
        .rejected   (Rejected_A_DO),
        .fill       (Fill_A_DO)
    );

    vote_window #(.WINDOW(WINDOW)) u_win_v (
        .clk        (Clk_CI),
        .reset      (Reset_RI),
        .accept     (accept),
        .label_bit  (LabelIn_V_DI[0]),
        .distance   (DistanceIn_V_DI),
        .thresh     (DistThresh_DI),
        .prev_label (label_v_q),
        .vote       (vote_v),
        .rejected   (Rejected_V_DO),
        .fill       (Fill_V_DO)
    );

    // Capture the votes when leaving VOTE; they stay put through OUT and the following IDLE
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            label_a_q <= 1'b0;
            label_v_q <= 1'b0;
        end else if (state == ST_VOTE) begin
            label_a_q <= vote_a;
            label_v_q <= vote_v;
        end
    end

    assign LabelOut_A_DO = {{(LABEL_WIDTH-1){1'b0}}, label_a_q};
    assign LabelOut_V_DO = {{(LABEL_WIDTH-1){1'b0}}, label_v_q};

endmodule

// File: tb/tb_hdc_vote_filter.sv
// tb/tb_hdc_vote_filter.sv - directed table-driven bench for hdc_vote_filter
module tb_hdc_vote_filter;
    import hdc_vote_filter_pkg::*;

    localparam int CW = vote_count_width(VOTE_WINDOW);

    logic                      clk;
    logic                      rst;
    logic                      valid_in;
    logic                      ready_out;
    logic [LABEL_WIDTH-1:0]    label_a;
    logic [LABEL_WIDTH-1:0]    label_v;
    logic [DISTANCE_WIDTH-1:0] dist_a;
    logic [DISTANCE_WIDTH-1:0] dist_v;
    logic [DISTANCE_WIDTH-1:0] thresh;
    logic                      valid_out;
    logic                      ready_in;
    logic [LABEL_WIDTH-1:0]    out_a;
    logic [LABEL_WIDTH-1:0]    out_v;
    logic                      rej_a;
    logic                      rej_v;
    logic [CW-1:0]             fill_a;
    logic [CW-1:0]             fill_v;

    int vectors;
    int miscompares;

    hdc_vote_filter #(.WINDOW(VOTE_WINDOW)) dut (
        .Clk_CI          (clk),
        .Reset_RI        (rst),
        .ValidIn_SI      (valid_in),
        .ReadyOut_SO     (ready_out),
        .LabelIn_A_DI    (label_a),
        .LabelIn_V_DI    (label_v),
        .DistanceIn_A_DI (dist_a),
        .DistanceIn_V_DI (dist_v),
        .DistThresh_DI   (thresh),
        .ValidOut_SO     (valid_out),
        .ReadyIn_SI      (ready_in),
        .LabelOut_A_DO   (out_a),
        .LabelOut_V_DO   (out_v),
        .Rejected_A_DO   (rej_a),
        .Rejected_V_DO   (rej_v),
        .Fill_A_DO       (fill_a),
        .Fill_V_DO       (fill_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic la;
        logic lv;
        int   da;
        int   dv;
        int   thr;
        int   ea;
        int   ev;
        int   ra;
        int   rv;
        int   fa;
        int   fv;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic la, input logic lv, input int da, input int dv,
                                input int thr, input int ea, input int ev, input int ra,
                                input int rv, input int fa, input int fv);
        vec_t v;
        v.la = la; v.lv = lv; v.da = da; v.dv = dv; v.thr = thr;
        v.ea = ea; v.ev = ev; v.ra = ra; v.rv = rv; v.fa = fa; v.fv = fv;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s[%0d] got %0d want %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive_inputs(input vec_t v);
        logic [LABEL_WIDTH-1:0] tmp;
        tmp = LABEL_WIDTH'($urandom);
        tmp[0] = v.la;
        label_a = tmp;
        tmp = LABEL_WIDTH'($urandom);
        tmp[0] = v.lv;
        label_v = tmp;
        dist_a = DISTANCE_WIDTH'(v.da);
        dist_v = DISTANCE_WIDTH'(v.dv);
        thresh = DISTANCE_WIDTH'(v.thr);
    endtask

    task automatic check_outputs(input vec_t v, input int idx);
        check("label_a", idx, int'(out_a), v.ea);
        check("label_v", idx, int'(out_v), v.ev);
        check("rej_a", idx, int'(rej_a), v.ra);
        check("rej_v", idx, int'(rej_v), v.rv);
        check("fill_a", idx, int'(fill_a), v.fa);
        check("fill_v", idx, int'(fill_v), v.fv);
    endtask

    // One full transaction with ReadyIn held high; called #1 after a rising edge in IDLE
    task automatic apply_vec(input int idx);
        check("ready_before", idx, int'(ready_out), 1);
        drive_inputs(tbl[idx]);
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("vout_lat1", idx, int'(valid_out), 0);
        check("ready_vote", idx, int'(ready_out), 0);
        @(posedge clk); #1;
        check("vout_lat2", idx, int'(valid_out), 1);
        check_outputs(tbl[idx], idx);
        @(posedge clk); #1;
        check("vout_done", idx, int'(valid_out), 0);
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            apply_vec(i);
        end
    endtask

    vec_t hv;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        valid_in    = 1'b0;
        ready_in    = 1'b1;
        label_a     = '0;
        label_v     = '0;
        dist_a      = '0;
        dist_v      = '0;
        thresh      = '0;

        // both rejected from empty windows, then steady A=1/V=0
        tbl[0]  = mk(1, 1, 150, 150, 100, 0, 0, 1, 1, 0, 0);
        tbl[1]  = mk(1, 0,  50,  50, 100, 1, 0, 0, 0, 1, 1);
        tbl[2]  = mk(1, 0,  50,  50, 100, 1, 0, 0, 0, 2, 2);
        tbl[3]  = mk(1, 0,  50,  50, 100, 1, 0, 0, 0, 3, 3);
        tbl[4]  = mk(1, 0, 100,  50, 100, 1, 0, 0, 0, 4, 4);
        tbl[5]  = mk(0, 0, 150,  50, 100, 1, 0, 1, 0, 4, 5);
        // window saturation: A eight 1s then eight 0s, V the mirror image
        for (int k = 0; k < 8; k++) begin
            tbl[6 + k] = mk(1, 0, 10, 10, 100, 1, 0, 0, 0, k + 1, k + 1);
        end
        for (int k = 1; k <= 8; k++) begin
            tbl[13 + k] = mk(0, 1, 10, 10, 100, (k <= 4) ? 1 : 0, (k >= 5) ? 1 : 0,
                             0, 0, 8, 8);
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", 0, int'(ready_out), 1);
        check("rst_vout", 0, int'(valid_out), 0);
        check("rst_label_a", 0, int'(out_a), 0);
        check("rst_label_v", 0, int'(out_v), 0);
        check("rst_fill_a", 0, int'(fill_a), 0);
        check("rst_fill_v", 0, int'(fill_v), 0);
        check("rst_rej_a", 0, int'(rej_a), 0);
        check("rst_rej_v", 0, int'(rej_v), 0);

        apply_range(0, 5);

        // downstream stalls for 5 cycles while a new result keeps asking
        hv = mk(1, 1, 50, 50, 100, 1, 0, 0, 0, 5, 6);
        ready_in = 1'b0;
        drive_inputs(hv);
        valid_in = 1'b1;
        @(posedge clk); #1;
        check("hold_vote_vout", 0, int'(valid_out), 0);
        @(posedge clk); #1;
        check("hold_vout", 0, int'(valid_out), 1);
        check_outputs(hv, 100);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            check("hold_vout", c, int'(valid_out), 1);
            check("hold_ready", c, int'(ready_out), 0);
            check_outputs(hv, 100 + c);
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        check("hold_release_ready", 0, int'(ready_out), 1);
        check("hold_release_vout", 0, int'(valid_out), 0);
        check("hold_release_fill_a", 0, int'(fill_a), 5);
        valid_in = 1'b0;

        // reset lands on the VOTE cycle
        hv = mk(1, 1, 10, 10, 100, 1, 1, 0, 0, 6, 7);
        drive_inputs(hv);
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("vrst_vout", 0, int'(valid_out), 0);
        check("vrst_ready", 0, int'(ready_out), 1);
        check("vrst_fill_a", 0, int'(fill_a), 0);
        check("vrst_fill_v", 0, int'(fill_v), 0);
        check("vrst_label_a", 0, int'(out_a), 0);
        check("vrst_label_v", 0, int'(out_v), 0);
        check("vrst_rej_a", 0, int'(rej_a), 0);
        @(posedge clk); #1;
        check("vrst_vout_later", 0, int'(valid_out), 0);

        apply_range(6, 21);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hdc_vote_filter.md
HDC_VOTE_FILTER -- requirements
Module: hdc_vote_filter

Interface
REQ-001 SHALL have parameter WINDOW, default 8, meaning the number of accepted labels kept per modality; legal range 2..16.
REQ-002 SHALL have port Clk_CI, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_RI, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ValidIn_SI, input, 1 bit: an associative-memory result is present.
REQ-005 SHALL have port ReadyOut_SO, output, 1 bit: the block accepts a result.
REQ-006 SHALL have ports LabelIn_A_DI and LabelIn_V_DI, input, `LABEL_WIDTH each: arousal and valence labels; bit 0 is the class, other bits are ignored.
REQ-007 SHALL have ports DistanceIn_A_DI and DistanceIn_V_DI, input, `DISTANCE_WIDTH each: Hamming distances of the labels.
REQ-008 SHALL have port DistThresh_DI, input, `DISTANCE_WIDTH: confidence threshold, sampled at accept.
REQ-009 SHALL have port ValidOut_SO, output, 1 bit: a filtered result is present.
REQ-010 SHALL have port ReadyIn_SI, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have ports LabelOut_A_DO and LabelOut_V_DO, output, `LABEL_WIDTH each: voted labels, zero-extended from 1 bit.
REQ-012 SHALL have ports Rejected_A_DO and Rejected_V_DO, output, 1 bit each: the current sample's label was gated out.
REQ-013 SHALL have ports Fill_A_DO and Fill_V_DO, output, `VOTE_COUNT_WIDTH each: number of labels currently held in each window.

Function
REQ-014 SHALL implement an FSM with states IDLE, VOTE and OUT.
- IDLE -> VOTE on accept (ValidIn_SI & ReadyOut_SO).
- VOTE -> OUT unconditionally.
- OUT -> IDLE when ReadyIn_SI is high.
REQ-015 SHALL drive ReadyOut_SO high only in IDLE, and ValidOut_SO high only in OUT.
REQ-016 SHALL, on accept, for each modality independently:
- if distance <= DistThresh_DI: shift label bit 0 into a WINDOW-deep history.
- if distance > DistThresh_DI: leave the history unchanged and register Rejected=1; otherwise register Rejected=0.
REQ-017 SHALL maintain per modality a ones-count and a fill count that saturates at WINDOW.
- While fill < WINDOW: count += new bit.
- When fill == WINDOW: count += new bit - evicted oldest bit.
REQ-018 SHALL compute the vote in the VOTE cycle per modality:
- 2*count > fill -> 1.
- 2*count < fill -> 0.
- tie, including fill == 0 -> the previous voted label.
REQ-019 SHALL register the voted labels on entry to OUT, so ValidOut_SO rises on the 2nd rising edge after accept (latency 2); throughput is one result per 3 cycles when ReadyIn_SI is held high.
REQ-020 SHALL hold LabelOut_*, Rejected_* and Fill_* stable while ValidOut_SO is high and ReadyIn_SI is low.
REQ-021 SHALL ignore ValidIn_SI outside IDLE; a result is never accepted in the same cycle as the OUT->IDLE handshake.
REQ-022 SHALL size counters at `VOTE_COUNT_WIDTH = clog2(WINDOW+1) bits; the count never exceeds fill and never wraps.

Reset
REQ-023 SHALL, with Reset_RI high at a rising edge, in any state including mid-VOTE or mid-OUT:
- go to IDLE.
- clear histories, counts and fills to 0.
- clear LabelOut_*, Rejected_* and ValidOut_SO to 0.
- ReadyOut_SO is high in the first cycle after reset deasserts.

Structure
REQ-024 SHALL obtain `LABEL_WIDTH, `DISTANCE_WIDTH, `VOTE_WINDOW (default for WINDOW) and `VOTE_COUNT_WIDTH from const.vh.
REQ-025 SHALL instantiate the sub-module vote_window twice (arousal, valence); each instance holds the history, count, fill, gate compare and vote logic. The top level holds only the FSM and the output registers.

Verification
REQ-026 SHALL cover: threshold 100, labels A=1/V=0 at distance 50, three results -> outputs A=1, V=0, Rejected=0, Fill=1,2,3, and ValidOut_SO rising 2 edges after each accept.
REQ-027 SHALL cover: threshold 100, A distance 150 with label 0 after four accepted A=1 results -> Rejected_A_DO=1, Fill_A_DO=4, LabelOut_A_DO=1.
REQ-028 SHALL cover: WINDOW=8, eight 1s then eight 0s -> Fill saturates at 8; label switches to 0 on the 5th zero and stays 1 on the 4th zero (tie holds the previous label).
REQ-029 SHALL cover: ReadyIn_SI low for 5 cycles in OUT while ValidIn_SI stays high -> outputs stable, no second accept, ReadyOut_SO low throughout.
REQ-030 SHALL cover: Reset_RI pulsed in the VOTE cycle -> next cycle ValidOut_SO=0, Fill=0, labels=0, ReadyOut_SO=1.
REQ-031 SHALL cover: first result rejected on both modalities (fill 0) -> LabelOut=0 for both, Rejected=1 for both, Fill=0.
